// File: rtl/lzc_pipelined.sv
// rtl/lzc_pipelined.sv - pipelined leading zero/one counter; LZC_NORMALIZE_EN adds the out_norm shifter
module lzc_pipelined #(
    parameter int DATA_WIDTH  = 16,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_WIDTH   = 1,
    localparam int CW = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_mode,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CW-1:0]         out_count,
    output logic                  out_all,
`ifdef LZC_NORMALIZE_EN
    output logic [DATA_WIDTH-1:0] out_norm,
`endif
    output logic [TAG_WIDTH-1:0]  out_tag
);
    localparam int LEVELS    = $clog2(DATA_WIDTH);
    localparam int PW        = 1 << LEVELS;
    localparam int NB        = (PIPE_STAGES > 1) ? PIPE_STAGES - 1 : 1;
    localparam int TREE_DONE = (PIPE_STAGES > 1) ? LEVELS : 0;
    localparam int LAST      = PIPE_STAGES - 1;

    // Node i of a level covers an MSB-first segment; index 0 is the most significant.
    typedef struct packed {
        logic [PW-1:0]         all;
        logic [PW-1:0][CW-1:0] cnt;
    } node_vec_t;

    function automatic node_vec_t reduce(input node_vec_t n, input int lo, input int hi);
        node_vec_t     r;
        logic          a_hi;
        logic          a_lo;
        logic [CW-1:0] c_hi;
        logic [CW-1:0] c_lo;
        r = n;
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            if (lvl >= lo && lvl < hi) begin
                for (int i = 0; i < PW / 2; i++) begin
                    if (i < (PW >> (lvl + 1))) begin
                        a_hi     = r.all[2*i];
                        a_lo     = r.all[2*i+1];
                        c_hi     = r.cnt[2*i];
                        c_lo     = r.cnt[2*i+1];
                        r.all[i] = a_hi & a_lo;
                        r.cnt[i] = a_hi ? c_hi + c_lo : c_hi;
                    end
                end
            end
        end
        return r;
    endfunction

    logic                  en;
    logic                  v_q    [PIPE_STAGES];
    logic [DATA_WIDTH-1:0] data_q [PIPE_STAGES];
    logic [TAG_WIDTH-1:0]  tag_q  [PIPE_STAGES];
    logic                  mode_q;
    node_vec_t             nodes_q[PIPE_STAGES];
    node_vec_t             nodes_d[PIPE_STAGES];
    node_vec_t             view   [PIPE_STAGES];
    node_vec_t             leaves;
    node_vec_t             root;

    assign en        = ~out_valid | out_ready;
    assign in_ready  = en;
    assign out_valid = v_q[LAST];

    // Padding leaves never match the mode, so they cannot extend a run.
    for (genvar i = 0; i < PW; i++) begin : g_leaf
        if (i < DATA_WIDTH) begin : g_bit
            assign leaves.all[i] = (data_q[0][DATA_WIDTH-1-i] == mode_q);
        end else begin : g_pad
            assign leaves.all[i] = 1'b0;
        end
        assign leaves.cnt[i] = {{(CW-1){1'b0}}, leaves.all[i]};
    end

    assign view[0] = leaves;
    for (genvar s = 1; s < PIPE_STAGES; s++) begin : g_view
        assign view[s] = nodes_q[s];
    end

    always_comb begin
        for (int s = 0; s < PIPE_STAGES; s++) nodes_d[s] = '0;
        for (int s = 1; s < PIPE_STAGES; s++) begin
            nodes_d[s] = reduce(view[s-1], (LEVELS * (s - 1)) / NB, (LEVELS * s) / NB);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= 1'b0;
            for (int s = 0; s < PIPE_STAGES; s++) begin
                v_q[s]     <= 1'b0;
                data_q[s]  <= '0;
                tag_q[s]   <= '0;
                nodes_q[s] <= '0;
            end
        end else if (en) begin
            v_q[0]    <= in_valid;
            data_q[0] <= in_data;
            tag_q[0]  <= in_tag;
            mode_q    <= in_mode;
            for (int s = 1; s < PIPE_STAGES; s++) begin
                v_q[s]     <= v_q[s-1];
                data_q[s]  <= data_q[s-1];
                tag_q[s]   <= tag_q[s-1];
                nodes_q[s] <= nodes_d[s];
            end
        end
    end

    // With a single stage the whole tree sits after the input register.
    assign root      = reduce(view[LAST], TREE_DONE, LEVELS);
    assign out_count = out_valid ? root.cnt[0] : '0;
    assign out_all   = out_valid & root.all[0];
    assign out_tag   = out_valid ? tag_q[LAST] : '0;

`ifdef LZC_NORMALIZE_EN
    if (PIPE_STAGES > 1) begin : g_norm_reg
        logic [DATA_WIDTH-1:0] norm_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                norm_q <= '0;
            end else if (en) begin
                norm_q <= nodes_d[LAST].all[0] ? '0
                        : data_q[(LAST > 0) ? LAST - 1 : 0] << nodes_d[LAST].cnt[0];
            end
        end
        assign out_norm = out_valid ? norm_q : '0;
    end else begin : g_norm_comb
        assign out_norm = (out_valid && !out_all) ? data_q[0] << out_count : '0;
    end
`endif

endmodule

// File: tb/tb_lzc_pipelined.sv
// tb/tb_lzc_pipelined.sv - scoreboard bench for lzc_pipelined against a bit-walking reference model
module tb_lzc_pipelined;
    localparam int DW = 16;
    localparam int PS = 2;
    localparam int TW = 4;
    localparam int CW = $clog2(DW + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_mode = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [CW-1:0] out_count;
    logic          out_all;
    logic [TW-1:0] out_tag;
`ifdef LZC_NORMALIZE_EN
    logic [DW-1:0] out_norm;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;

    typedef struct {
        logic [31:0]   cnt;
        logic          all;
        logic [TW-1:0] tag;
        logic [DW-1:0] norm;
    } exp_t;
    exp_t sb[$];

    lzc_pipelined #(.DATA_WIDTH(DW), .PIPE_STAGES(PS), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
        .out_all(out_all),
`ifdef LZC_NORMALIZE_EN
        .out_norm(out_norm),
`endif
        .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic exp_t model(input logic [DW-1:0] d, input logic m, input logic [TW-1:0] t);
        exp_t e;
        int   n = 0;
        bit   run = 1'b1;
        for (int i = DW - 1; i >= 0; i--) begin
            if (run && d[i] == m) n++;
            else run = 1'b0;
        end
        e.cnt  = n;
        e.all  = (n == DW);
        e.tag  = t;
        e.norm = e.all ? '0 : d << n;
        return e;
    endfunction

    // Monitor: push on input transfer, pop and compare on output transfer, check stall stability.
    logic          prev_stall = 1'b0;
    logic [CW-1:0] prev_count;
    logic          prev_all;
    logic [TW-1:0] prev_tag;
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_count", out_count, prev_count);
                check("hold_all", out_all, prev_all);
                check("hold_tag", out_tag, prev_tag);
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got tag %0d expected no output", out_tag);
                end else begin
                    e = sb.pop_front();
                    check("count", out_count, e.cnt);
                    check("all", out_all, e.all);
                    check("tag", out_tag, e.tag);
`ifdef LZC_NORMALIZE_EN
                    check("norm", out_norm, e.norm);
`endif
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_data, in_mode, in_tag));
            prev_stall = out_valid && !out_ready;
            prev_count = out_count;
            prev_all   = out_all;
            prev_tag   = out_tag;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [DW-1:0] d, input logic m, input logic [TW-1:0] t);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        in_tag   = t;
    endtask

    function automatic logic [DW-1:0] rand_word(input logic m);
        logic [DW-1:0] w;
        w = DW'($urandom) >> $urandom_range(0, DW);
        return m ? ~w : w;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt;
        int base;
        int guard;
        logic [CW-1:0] s_count;
        logic          s_all;
        logic [TW-1:0] s_tag;
        logic          m;

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_all", out_all, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_in_ready", in_ready, 1);

        // Basic counts, all-bits words and latency of two cycles
        tick();
        drive(16'h0F00, 1'b0, 4'd3);
        @(negedge clk); check("lat_c0", out_valid, 0);
        tick();
        drive(16'hE123, 1'b1, 4'd1);
        @(negedge clk); check("lat_c1", out_valid, 0);
        tick();
        drive(16'hE123, 1'b0, 4'd2);
        @(negedge clk);
        check("lat_c2", out_valid, 1);
        check("first_count", out_count, 4);
        check("first_tag", out_tag, 3);
        tick(); drive(16'h0000, 1'b0, 4'd4);
        tick(); drive(16'hFFFF, 1'b1, 4'd5);
        tick(); drive(16'h0001, 1'b0, 4'd6);
        tick(); drive(16'h00A5, 1'b0, 4'd7);
        tick(); in_valid = 1'b0;
        repeat (4) tick();

        // Back-to-back: tags 0..7 on consecutive cycles, two cycles late
        for (int k = 0; k < 10; k++) begin
            if (k < 8) drive(rand_word(k[0]), k[0], TW'(k));
            else in_valid = 1'b0;
            @(negedge clk);
            if (k >= 2) begin
                check("b2b_valid", out_valid, 1);
                check("b2b_tag", out_tag, k - 2);
            end
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();

        // Backpressure: out_ready low for three cycles while a result waits
        base = n_out;
        nxt  = 0;
        for (int k = 0; k < 20; k++) begin
            out_ready = !(k >= 3 && k <= 5);
            if (nxt < 6) drive(rand_word(1'b0), 1'b0, TW'(nxt));
            else in_valid = 1'b0;
            @(negedge clk);
            if (k == 3) begin
                check("bp_valid", out_valid, 1);
                s_count = out_count; s_all = out_all; s_tag = out_tag;
            end
            if (k >= 3 && k <= 5) check("bp_in_ready", in_ready, 0);
            if (k > 3 && k <= 5) begin
                check("bp_held_count", out_count, s_count);
                check("bp_held_all", out_all, s_all);
                check("bp_held_tag", out_tag, s_tag);
            end
            if (in_valid && in_ready) nxt++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_deliveries", n_out - base, 6);
        check("bp_sb_empty", sb.size(), 0);

        // Reset with two words in flight
        out_ready = 1'b0;
        drive(16'h00F0, 1'b0, 4'd11);
        tick();
        drive(16'h0FF0, 1'b0, 4'd12);
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_count", out_count, 0);
        check("mid_rst_in_ready", in_ready, 1);
        base = n_out;
        out_ready = 1'b1;
        tick();
        drive(16'h3000, 1'b0, 4'd9);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        check("rst_deliveries", n_out - base, 1);

        // Randomized traffic with random backpressure
        for (int k = 0; k < 400; k++) begin
            m = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 7) begin
                case ($urandom_range(0, 9))
                    0:       drive(m ? '1 : '0, m, TW'($urandom));
                    default: drive(rand_word(m), m, TW'($urandom));
                endcase
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (sb.size() > 0 && guard < 50) begin
            tick();
            guard++;
        end
        check("drain_empty", sb.size(), 0);
        repeat (2) tick();
        @(negedge clk);
        check("idle_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lzc_pipelined.md
Name: lzc_pipelined

Overview:
- Parametrised, pipelined leading-zero/leading-one counter with a valid/ready stream interface on both sides.
- Counts consecutive bits equal to the selected polarity, starting from the MSB. Reports an all-bits flag so an all-zero or all-one word is never an undefined result.
- Feeds the posit/float normalisation path (regime decode, post-add renormalisation). Replaces unregistered single-cycle detectors on timing-critical paths.

Parameters:
- DATA_WIDTH, 16, width of the input word; legal range 2 to 256.
- PIPE_STAGES, 2, register stages from input acceptance to output; legal range 1 to 4.
- TAG_WIDTH, 1, width of the sideband tag carried alongside each word; minimum 1.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept an input word this cycle.
- in_data  input  DATA_WIDTH  word to scan.
- in_mode  input  1  0 = count leading zeros; 1 = count leading ones.
- in_tag  input  TAG_WIDTH  sideband; passed through unchanged.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_count  output  CW  leading count, where CW = $clog2(DATA_WIDTH+1).
- out_all  output  1  every bit of the input equals the mode polarity.
- out_tag  output  TAG_WIDTH  tag of the word that produced this result.

Behaviour:
- Count definition:
  - out_count = number of consecutive bits, starting at in_data[DATA_WIDTH-1], equal to in_mode.
  - Range is 0 to DATA_WIDTH.
  - out_all = 1 exactly when out_count == DATA_WIDTH.
  - No undefined or latched value for any input.
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Pipeline enable:
  - Single global enable: en = ~out_valid | out_ready; in_ready = en (combinational).
  - When en = 0, every stage register (data, mode, tag, partial results, valid bits) holds its value.
- Latency:
  - With no stall, an input accepted at edge N presents out_valid = 1 with its result after edge N+PIPE_STAGES.
  - Throughput is one word per cycle.
- Bubbles:
  - Each stage has a valid bit; a cycle with no input transfer inserts a bubble.
  - Bubbles advance while en = 1, so the pipeline drains with no further input.
- Ordering and integrity: strict order; no result is dropped or duplicated under any in_valid/out_ready pattern.
- Output stability: while out_valid = 1 and out_ready = 0, out_count, out_all and out_tag stay stable.
- Tree partition:
  - Implement as a log2 priority tree of (all, count) pairs merged per level.
  - Levels are distributed across PIPE_STAGES as evenly as possible; the first register stage captures the raw inputs.
  - Results must be bit-identical for every PIPE_STAGES value.
- Non-power-of-two DATA_WIDTH: pad LSB-side with the complement of in_mode. Padding never extends the count.
- Reset:
  - On an edge with rst = 1: all stage valid bits, out_valid, out_count, out_all and out_tag clear to 0.
  - in_ready reads 1 in the cycle after reset.
  - Words in flight are discarded; reset overrides any simultaneous transfer.
- Simultaneous input and output transfer on a full pipeline is legal and keeps occupancy constant.

Optional Feature:
- Macro: LZC_NORMALIZE_EN.
- Defined:
  - Adds output port out_norm [DATA_WIDTH-1:0] = in_data shifted left by out_count, zero-filled.
  - When out_all = 1, out_norm = 0.
  - The shift is registered in the final stage; latency is unchanged.
  - out_norm obeys the same stall and reset rules as out_count (reset value 0).
- Undefined: port and shifter are absent; all other behaviour is identical.

Test Plan:
All scenarios use DATA_WIDTH=16, PIPE_STAGES=2, TAG_WIDTH=4.
1. Basic counts: in_data=16'h0F00, mode=0, tag=3 -> two cycles later out_count=4, out_all=0, out_tag=3. Then 16'hE123, mode=1 -> 3; the same word with mode=0 -> 0.
2. All-bits: 16'h0000 mode=0 -> count 16, all=1. 16'hFFFF mode=1 -> count 16, all=1. 16'h0001 mode=0 -> count 15, all=0.
3. Back-to-back: 8 consecutive words with out_ready=1 -> 8 results on 8 consecutive cycles starting 2 cycles after the first, tags 0 to 7 in order.
4. Backpressure: stream tags 0 to 5; drop out_ready for 3 cycles while out_valid=1 -> in_ready=0 in those cycles, outputs held. After release: tags 0 to 5 each delivered once, in order.
5. Reset mid-operation: rst=1 for one cycle with 2 words in flight -> out_valid=0 and out_count=0 after that edge. The in-flight words never appear; a word issued next cycle returns normally.
6. LZC_NORMALIZE_EN defined: 16'h0F00 mode=0 -> out_norm=16'hF000. 16'h0000 mode=0 -> out_norm=16'h0000. 16'h00A5 mode=0 -> out_count=8, out_norm=16'hA500.
